msg_entry_ctrl: RTL and testbench
=================================

# msg_entry_ctrl

Programming-mode front end for the scrolling display. It turns switch settings and a debounced enter pulse into sequential word writes on port A of the display BRAM, and tracks the committed message length. It also drives the LED bank as an entry-progress bar. The block sits directly upstream of the BRAM that the scroll/readout path reads; its `msg_len` output tells that path how many words to cycle through.

## Interface
Parameters:
- `DEPTH` — 16 — message capacity in 16-bit words; power of two, 2..16.
- `AW` — 4 — write-address width; must satisfy 2^AW = DEPTH.

Ports:
- `clk` — in — 1 — system clock; sole clock domain.
- `reset` — in — 1 — synchronous, active-high reset.
- `prog` — in — 1 — programming-mode level; rising edge starts entry, low level ends entry.
- `enter` — in — 1 — one-cycle pulse from the debouncer; accept current `sw` word.
- `clear` — in — 1 — one-cycle pulse; discards the committed message (IDLE only).
- `sw` — in — 16 — word to be written.
- `wr_en` — out — 1 — BRAM port-A write enable, registered.
- `wr_addr` — out — AW — BRAM port-A address, registered.
- `wr_data` — out — 16 — BRAM port-A data, registered.
- `msg_len` — out — AW+1 — committed message length in words, 0..DEPTH.
- `entry_active` — out — 1 — high while in ENTRY; holds the scroll path stopped.
- `full` — out — 1 — high in ENTRY when `DEPTH` words have been accepted.
- `done` — out — 1 — one-cycle pulse when a non-empty message is committed.
- `overflow` — out — 1 — one-cycle pulse when `enter` arrives while full.
- `led` — out — 16 — entry-progress thermometer.

## Operation
- Internal `prog_q` register samples `prog` each cycle. Rising edge = `prog & ~prog_q`.
- `prog_q` resets to 1, so a `prog` held high through reset release does not start entry.
- Internal `cnt` (AW+1 bits) counts words accepted in the current entry session.

States: IDLE, ENTRY, COMMIT.

IDLE:
- `entry_active`=0, `full`=0, `led`=0.
- `clear` pulse sets `msg_len` to 0.
- `enter` is ignored.
- A `prog` rising edge clears `cnt` to 0 and moves to ENTRY.

ENTRY:
- `entry_active`=1.
- `enter` with `cnt` < DEPTH:
  - next cycle: `wr_en`=1, `wr_addr`=`cnt`[AW-1:0], `wr_data`=`sw` as sampled in the `enter` cycle;
  - `cnt` increments.
- `enter` with `cnt` == DEPTH: no write; `overflow` pulses the next cycle.
- `full` = (`cnt` == DEPTH).
- `led`[i] = (i < `cnt`) for i in 0..15.
- `clear` is ignored.
- `prog` low moves to COMMIT. If `enter` arrives in that same cycle, the write is still accepted and included in `cnt`.

COMMIT (exactly one cycle, then IDLE):
- If `cnt` != 0: `msg_len` <= `cnt`, and `done` pulses in the COMMIT cycle.
- If `cnt` == 0: `msg_len` keeps its previous value, and there is no `done` (empty session = abort, old message preserved).
- `enter` is ignored. `wr_en` may still show the write from an `enter` in the last ENTRY cycle.

Reset (synchronous, any state):
- State = IDLE, `cnt`=0, `msg_len`=0, `prog_q`=1.
- All outputs 0: `wr_en`, `wr_addr`, `wr_data`, `entry_active`, `full`, `done`, `overflow`, `led`.
- A write that would have landed in the reset cycle is suppressed.
- Reset mid-ENTRY discards the session; BRAM contents already written are left as-is, but `msg_len`=0.

## Timing
- `enter` sampled at edge N → `wr_en` high for exactly cycle N+1, with `wr_addr`/`wr_data` valid in the same cycle.
- Back-to-back `enter` pulses on consecutive cycles produce writes on consecutive cycles at consecutive addresses.
- `prog` rise sampled at edge N → `entry_active` high from cycle N+1.
- `prog` low sampled in ENTRY at edge N → COMMIT in cycle N+1, `msg_len` updated at edge N+2, IDLE in cycle N+2.
- `wr_addr`/`wr_data` hold their last values when `wr_en`=0.
- `full` and `led` update the cycle after `cnt` changes.
- Width rule: `cnt` saturates at DEPTH and never wraps; addresses 0..DEPTH-1 only.

## Test plan
- Reset, `prog` rise, three `enter` pulses with `sw`=16'h1234, 16'hABCD, 16'h00FF, `prog` low → writes at addr 0,1,2 with those data, one cycle after each enter; `done` pulse; `msg_len`=3; `led`=16'h0007 before commit, 0 after.
- `prog` held high through reset release → stays IDLE, no writes; `prog` low then high → ENTRY.
- 17 `enter` pulses with DEPTH=16 → 16 writes at addr 0..15; `full`=1 after the 16th; 17th gives `overflow` pulse and no write; `led`=16'hFFFF; commit gives `msg_len`=16.
- Committed `msg_len`=3, then a session with zero enters → no `done`, `msg_len` stays 3; `clear` in IDLE → `msg_len`=0; `clear` during ENTRY → no effect.
- `enter` in the same cycle `prog` falls (after 1 prior word) → write at addr 1 occurs, `msg_len`=2.
- `reset` asserted after 2 words in ENTRY, coincident with an `enter` → no write in the following cycle, IDLE, `msg_len`=0, all outputs 0.

Source files
------------

// File: rtl/msg_entry_ctrl.sv
// Programming-mode front end: turns switch words + enter pulses into sequential BRAM port-A writes.
// Latency: write issued the cycle after enter; msg_len updates at the end of the one-cycle COMMIT state.
// No backpressure: enters past capacity are dropped and flagged with an overflow pulse.
module msg_entry_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog,
    input  logic          enter,
    input  logic          clear,
    input  logic [15:0]   sw,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic [AW:0]   msg_len,
    output logic          entry_active,
    output logic          full,
    output logic          done,
    output logic          overflow,
    output logic [15:0]   led
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        prog_q;
    logic [AW:0] cnt;
    logic        prog_rise;
    logic        cnt_full;
    logic        accept;

    assign prog_rise = prog & ~prog_q;
    assign cnt_full  = (cnt == (AW+1)'(DEPTH));
    // An enter in the cycle prog drops is still taken, since we are still in ENTRY.
    assign accept    = (state == S_ENTRY) && enter && !cnt_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (prog_rise) state_nxt = S_ENTRY;
            S_ENTRY:  if (!prog)     state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        entry_active = (state == S_ENTRY);
        full         = (state == S_ENTRY) && cnt_full;
        done         = (state == S_COMMIT) && (cnt != '0);
        for (int i = 0; i < 16; i++) begin
            led[i] = (state == S_ENTRY) && (i < int'(cnt));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prog_q   <= 1'b1;
            cnt      <= '0;
            msg_len  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            overflow <= 1'b0;
        end else begin
            prog_q   <= prog;
            wr_en    <= accept;
            overflow <= (state == S_ENTRY) && enter && cnt_full;
            if (accept) begin
                wr_addr <= cnt[AW-1:0];
                wr_data <= sw;
            end
            if ((state == S_IDLE) && prog_rise) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
            // An empty session leaves the previous message in place.
            if ((state == S_IDLE) && clear) begin
                msg_len <= '0;
            end else if ((state == S_COMMIT) && (cnt != '0)) begin
                msg_len <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_msg_entry_ctrl.sv
// Directed bench for msg_entry_ctrl: inputs driven 1ns after each rising edge, outputs checked there.
// Latency: checks sample outputs 1ns after the edge that registers them.
// No backpressure: bench drives stimulus unconditionally.
module tb_msg_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog;
    logic        enter;
    logic        clear;
    logic [15:0] sw;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  msg_len;
    logic        entry_active;
    logic        full;
    logic        done;
    logic        overflow;
    logic [15:0] led;

    int n_cmp = 0;
    int n_err = 0;
    bit seq_done = 1'b0;

    msg_entry_ctrl #(.DEPTH(16), .AW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .prog         (prog),
        .enter        (enter),
        .clear        (clear),
        .sw           (sw),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .msg_len      (msg_len),
        .entry_active (entry_active),
        .full         (full),
        .done         (done),
        .overflow     (overflow),
        .led          (led)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        if (!seq_done) begin
            n_err++;
            $error("FAIL timeout: directed sequence did not complete");
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wr_en"}, wr_en, 1'b0);
        chk({tag, ".wr_addr"}, wr_addr, 4'h0);
        chk({tag, ".wr_data"}, wr_data, 16'h0000);
        chk({tag, ".msg_len"}, msg_len, 5'd0);
        chk({tag, ".entry_active"}, entry_active, 1'b0);
        chk({tag, ".full"}, full, 1'b0);
        chk({tag, ".done"}, done, 1'b0);
        chk({tag, ".overflow"}, overflow, 1'b0);
        chk({tag, ".led"}, led, 16'h0000);
    endtask

    initial begin
        logic [16:0] therm;
        reset = 1'b1; prog = 1'b0; enter = 1'b0; clear = 1'b0; sw = 16'h0000;
        step(); step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        prog = 1'b1; step();
        chk("t1.entry_active", entry_active, 1'b1);
        chk("t1.led0", led, 16'h0000);
        chk("t1.wr_en_idle", wr_en, 1'b0);
        enter = 1'b1; sw = 16'h1234; step();
        chk("t1.w0.en", wr_en, 1'b1);
        chk("t1.w0.addr", wr_addr, 4'd0);
        chk("t1.w0.data", wr_data, 16'h1234);
        chk("t1.w0.led", led, 16'h0001);
        sw = 16'hABCD; step();
        chk("t1.w1.en", wr_en, 1'b1);
        chk("t1.w1.addr", wr_addr, 4'd1);
        chk("t1.w1.data", wr_data, 16'hABCD);
        sw = 16'h00FF; step();
        chk("t1.w2.addr", wr_addr, 4'd2);
        chk("t1.w2.data", wr_data, 16'h00FF);
        enter = 1'b0; sw = 16'h5A5A; step();
        chk("t1.idle_en", wr_en, 1'b0);
        chk("t1.hold_addr", wr_addr, 4'd2);
        chk("t1.hold_data", wr_data, 16'h00FF);
        chk("t1.led3", led, 16'h0007);
        chk("t1.full", full, 1'b0);
        prog = 1'b0; step();
        chk("t1.commit.done", done, 1'b1);
        chk("t1.commit.active", entry_active, 1'b0);
        chk("t1.commit.led", led, 16'h0000);
        chk("t1.commit.len_old", msg_len, 5'd0);
        step();
        chk("t1.len", msg_len, 5'd3);
        chk("t1.done_off", done, 1'b0);

        enter = 1'b1; step(); enter = 1'b0;
        chk("t2.idle_enter", wr_en, 1'b0);
        prog = 1'b1; step();
        chk("t2.active", entry_active, 1'b1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("t2.clear_entry", msg_len, 5'd3);
        prog = 1'b0; step();
        chk("t2.no_done", done, 1'b0);
        step();
        chk("t2.len_kept", msg_len, 5'd3);
        clear = 1'b1; step(); clear = 1'b0;
        chk("t2.clear_idle", msg_len, 5'd0);

        prog = 1'b1; step();
        enter = 1'b1; sw = 16'h1111; step();
        chk("t3.w0.addr", wr_addr, 4'd0);
        sw = 16'h2222; prog = 1'b0; step();
        enter = 1'b0;
        chk("t3.w1.en", wr_en, 1'b1);
        chk("t3.w1.addr", wr_addr, 4'd1);
        chk("t3.w1.data", wr_data, 16'h2222);
        chk("t3.done", done, 1'b1);
        step();
        chk("t3.len", msg_len, 5'd2);
        chk("t3.wr_off", wr_en, 1'b0);

        prog = 1'b1; step();
        for (int i = 0; i < 16; i++) begin
            enter = 1'b1; sw = 16'hA000 + 16'(i); step();
            therm = (17'd1 << (i + 1)) - 17'd1;
            n_cmp += 5;
            if (wr_en !== 1'b1) begin
                n_err++;
                $error("FAIL t4.en[%0d] observed=%0h expected=1", i, wr_en);
            end
            if (wr_addr !== 4'(i)) begin
                n_err++;
                $error("FAIL t4.addr[%0d] observed=%0h expected=%0h", i, wr_addr, 4'(i));
            end
            if (wr_data !== (16'hA000 + 16'(i))) begin
                n_err++;
                $error("FAIL t4.data[%0d] observed=%0h expected=%0h", i, wr_data, 16'hA000 + 16'(i));
            end
            if (led !== therm[15:0]) begin
                n_err++;
                $error("FAIL t4.led[%0d] observed=%0h expected=%0h", i, led, therm[15:0]);
            end
            if (full !== (i == 15)) begin
                n_err++;
                $error("FAIL t4.full[%0d] observed=%0h expected=%0h", i, full, (i == 15));
            end
        end
        sw = 16'hBEEF; step();
        enter = 1'b0;
        chk("t4.ovf.en", wr_en, 1'b0);
        chk("t4.ovf.pulse", overflow, 1'b1);
        chk("t4.ovf.addr", wr_addr, 4'd15);
        chk("t4.ovf.data", wr_data, 16'hA00F);
        chk("t4.ovf.led", led, 16'hFFFF);
        step();
        chk("t4.ovf.off", overflow, 1'b0);
        chk("t4.full_hold", full, 1'b1);
        prog = 1'b0; step();
        chk("t4.done", done, 1'b1);
        step();
        chk("t4.len", msg_len, 5'd16);
        chk("t4.full_idle", full, 1'b0);

        prog = 1'b1; step();
        enter = 1'b1; sw = 16'h5555; step();
        sw = 16'h6666; step();
        chk("t5.w1.addr", wr_addr, 4'd1);
        sw = 16'h7777; reset = 1'b1; step();
        enter = 1'b0;
        chk_all_zero("t5");

        step(); reset = 1'b0; step(); step();
        chk("t6.held_active", entry_active, 1'b0);
        chk("t6.held_wr", wr_en, 1'b0);
        prog = 1'b0; step();
        chk("t6.low_active", entry_active, 1'b0);
        prog = 1'b1; step();
        chk("t6.rise_active", entry_active, 1'b1);

        seq_done = 1'b1;
        if (n_err != 0 || n_cmp == 0) begin
            $error("FAIL summary: %0d mismatches over %0d comparisons", n_err, n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
